// File: rtl/cdr_loop_ctrl_if.sv
// Phase-detector input and loop-status output bundle for cdr_loop_ctrl.
interface cdr_loop_ctrl_if #(
  parameter int PH_W = 3
);
  logic            pd_valid;
  logic            pd;
  logic [PH_W-1:0] phase_sel;
  logic            phase_step;
  logic            phase_dir;
  logic            locked;
  logic [1:0]      state;

  modport master (
    output pd_valid, pd,
    input  phase_sel, phase_step, phase_dir, locked, state
  );

  modport slave (
    input  pd_valid, pd,
    output phase_sel, phase_step, phase_dir, locked, state
  );
endinterface

// File: rtl/cdr_loop_ctrl.sv
// CDR digital loop controller: bang-bang vote filter, phase-select stepping,
// acquisition/tracking/lock sequencing and idle timeout.
module cdr_loop_ctrl #(
  parameter int PH_W       = 3,
  parameter int ACC_W      = 6,
  parameter int ACQ_THR    = 4,
  parameter int TRK_THR    = 16,
  parameter int ACQ_LEN    = 64,
  parameter int LOCK_WIN   = 32,
  parameter int LOCK_STEPS = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  cdr_loop_ctrl_if.slave bus
);

  localparam int ACQ_CW  = $clog2(ACQ_LEN + 1);
  localparam int WIN_CW  = $clog2(LOCK_WIN + 1);
  localparam int STEP_CW = $clog2(LOCK_WIN + 2);
  localparam int IDLE_CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   vote_q, vote_d, vote_sum, thr;
  logic [ACQ_CW-1:0]         acq_q, acq_d;
  logic [WIN_CW-1:0]         win_q, win_d;
  logic [STEP_CW-1:0]        steps_q, steps_d, steps_sum;
  logic [IDLE_CW-1:0]        idle_q, idle_d;
  logic [PH_W-1:0]           sel_q, sel_d;
  logic                      dir_q, dir_d;
  logic                      step_q, step_d;
  logic                      locked_q, locked_d;
  logic                      hit_up, hit_dn, hit;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      vote_q   <= '0;
      acq_q    <= '0;
      win_q    <= '0;
      steps_q  <= '0;
      idle_q   <= '0;
      sel_q    <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vote_q   <= vote_d;
      acq_q    <= acq_d;
      win_q    <= win_d;
      steps_q  <= steps_d;
      idle_q   <= idle_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      locked_q <= locked_d;
    end
  end

  // Next-state: en=0 beats timeout beats window/acquire transitions beats the
  // normal update; a threshold step is still applied alongside a state change.
  always_comb begin
    state_d   = state_q;
    vote_d    = vote_q;
    acq_d     = acq_q;
    win_d     = win_q;
    steps_d   = steps_q;
    idle_d    = idle_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    locked_d  = locked_q;
    thr       = (state_q == ACQUIRE) ? ACC_W'(ACQ_THR) : ACC_W'(TRK_THR);
    vote_sum  = vote_q;
    hit_up    = 1'b0;
    hit_dn    = 1'b0;
    hit       = 1'b0;
    steps_sum = steps_q;

    if (bus.pd_valid) begin
      vote_sum = bus.pd ? (vote_q + ACC_W'(1)) : (vote_q - ACC_W'(1));
      hit_up   = (vote_sum == thr);
      hit_dn   = (vote_sum == -thr);
      hit      = hit_up || hit_dn;
    end
    steps_sum = steps_q + (hit ? STEP_CW'(1) : STEP_CW'(0));

    if (!en || state_q == IDLE) begin
      state_d  = en ? ACQUIRE : IDLE;
      vote_d   = '0;
      acq_d    = '0;
      win_d    = '0;
      steps_d  = '0;
      idle_d   = '0;
      locked_d = 1'b0;
    end else if (!bus.pd_valid && idle_q == IDLE_CW'(TIMEOUT - 1)) begin
      state_d  = ACQUIRE;
      vote_d   = '0;
      acq_d    = '0;
      win_d    = '0;
      steps_d  = '0;
      idle_d   = '0;
      locked_d = 1'b0;
    end else if (!bus.pd_valid) begin
      idle_d = idle_q + IDLE_CW'(1);
    end else begin
      idle_d = '0;
      vote_d = hit ? '0 : vote_sum;
      if (hit) begin
        sel_d  = hit_up ? (sel_q + PH_W'(1)) : (sel_q - PH_W'(1));
        dir_d  = hit_up;
        step_d = 1'b1;
      end
      if (state_q == ACQUIRE) begin
        if (acq_q == ACQ_CW'(ACQ_LEN - 1)) begin
          state_d = TRACK;
          acq_d   = '0;
          vote_d  = '0;
          win_d   = '0;
          steps_d = '0;
        end else begin
          acq_d = acq_q + ACQ_CW'(1);
        end
      end else if (win_q == WIN_CW'(LOCK_WIN - 1)) begin
        win_d   = '0;
        steps_d = '0;
        if (state_q == TRACK && steps_sum <= STEP_CW'(LOCK_STEPS)) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end else if (state_q == LOCKED && steps_sum > STEP_CW'(LOCK_STEPS)) begin
          state_d  = TRACK;
          locked_d = 1'b0;
        end
      end else begin
        win_d   = win_q + WIN_CW'(1);
        steps_d = steps_sum;
      end
    end
  end

  assign bus.phase_sel  = sel_q;
  assign bus.phase_step = step_q;
  assign bus.phase_dir  = dir_q;
  assign bus.locked     = locked_q;
  assign bus.state      = state_q;

endmodule
